// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   XLEN    : machine word width in bits.
//   state_e : loader FSM states.
package imem_loader_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ST_LEN  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear of byte position and shift register
//   push_i     : accept byte_i this cycle
//   byte_i     : incoming byte
//   last_o     : the byte being offered now is the 4th of its word
//   word_o     : assembled word {byte_i, b2, b1, b0}; valid when last_o
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            push_i,
  input  logic [7:0]      byte_i,
  output logic            last_o,
  output logic [XLEN-1:0] word_o
);

  logic [1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] sh_q,  sh_d;

  // Bytes enter at the top and shift down, so after four pushes the
  // first byte sits in [7:0].
  assign word_o = {byte_i, sh_q[XLEN-1:8]};
  assign last_o = (cnt_q == 2'd3);

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (clr_i) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (push_i) begin
      cnt_d = cnt_q + 2'd1;
      sh_d  = word_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a byte stream of
//   N (4 bytes LE) | N words (4 bytes LE each) | XOR checksum byte
// and writes the payload words to instruction memory, holding the core in
// reset until a good checksum arrives.
//   clk, rst_n                : clock, async active-low reset
//   in_valid/in_data/in_ready : byte stream handshake
//   restart                   : start a new load (honoured in DONE/ERR only)
//   mem_we/mem_a/mem_wd       : instruction memory write port
//   cpu_rst_n                 : core hold, high only in DONE
//   done/error                : load status
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned     SIZE      = 32768,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  input  logic            restart,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  output logic            cpu_rst_n,
  output logic            done,
  output logic            error
);

  localparam int WCW = $clog2(SIZE) + 1;
  // Word-aligned base; the low address bits are forced to zero.
  localparam logic [XLEN-3:0] BASE_W = BASE_ADDR[XLEN-1:2];

  state_e          state_q, state_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d, len_q, len_d, wcnt_inc;
  logic [7:0]      xor_q, xor_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_a_q, mem_a_d, mem_wd_q, mem_wd_d;
  logic            rdy_q, done_q, err_q, run_q;

  logic            acc, asm_push, asm_clr, asm_last;
  logic [XLEN-1:0] asm_word;

  assign acc      = in_valid && rdy_q;
  assign asm_push = acc && (state_q == ST_LEN || state_q == ST_DATA);
  assign wcnt_inc = wcnt_q + WCW'(1);

  word_assembler u_asm (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (asm_clr),
    .push_i (asm_push),
    .byte_i (in_data),
    .last_o (asm_last),
    .word_o (asm_word)
  );

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    len_d    = len_q;
    xor_d    = xor_q;
    mem_we_d = 1'b0;
    mem_a_d  = mem_a_q;
    mem_wd_d = mem_wd_q;
    asm_clr  = 1'b0;
    unique case (state_q)
      ST_LEN: begin
        if (acc && asm_last) begin
          if (asm_word == '0)                 state_d = ST_CSUM;
          else if (asm_word > XLEN'(SIZE))    state_d = ST_ERR;
          else begin
            // N <= SIZE here, so it fits in the word-counter width.
            len_d   = asm_word[WCW-1:0];
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (acc) begin
          xor_d = xor_q ^ in_data;
          if (asm_last) begin
            mem_we_d = 1'b1;
            mem_wd_d = asm_word;
            mem_a_d  = {BASE_W + (XLEN-2)'(wcnt_q), 2'b00};
            wcnt_d   = wcnt_inc;
            if (wcnt_inc == len_q) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (acc) state_d = (in_data == xor_q) ? ST_DONE : ST_ERR;
      end
      ST_DONE, ST_ERR: begin
        if (restart) begin
          state_d = ST_LEN;
          wcnt_d  = '0;
          len_d   = '0;
          xor_d   = '0;
          asm_clr = 1'b1;
        end
      end
      default: state_d = ST_LEN;
    endcase
  end

  // Status outputs are registered from the next state so they change on
  // the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LEN;
      wcnt_q   <= '0;
      len_q    <= '0;
      xor_q    <= '0;
      mem_we_q <= 1'b0;
      mem_a_q  <= {BASE_W, 2'b00};
      mem_wd_q <= '0;
      rdy_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      len_q    <= len_d;
      xor_q    <= xor_d;
      mem_we_q <= mem_we_d;
      mem_a_q  <= mem_a_d;
      mem_wd_q <= mem_wd_d;
      rdy_q    <= (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
      done_q   <= (state_d == ST_DONE);
      err_q    <= (state_d == ST_ERR);
      run_q    <= (state_d == ST_DONE);
    end
  end

  assign in_ready  = rdy_q;
  assign mem_we    = mem_we_q;
  assign mem_a     = mem_a_q;
  assign mem_wd    = mem_wd_q;
  assign cpu_rst_n = run_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule
